// File: rtl/lbp_stream_engine_if.sv
// Gray-memory read port and LBP result write port of the LBP stream engine.
// The master side is the engine; the slave side is the memory / result sink.
interface lbp_stream_engine_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
);
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_ready;
    logic [PIX_W-1:0]  gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;

    modport master (
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
        input  gray_ready, gray_data
    );

    modport slave (
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
        output gray_ready, gray_data
    );
endinterface

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 local-binary-pattern engine: raster read of a gray image, two line buffers,
// one LBP code per interior pixel two edges after the bottom-right pixel is accepted; optional zero border pass.
module lbp_stream_engine #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 14,
    parameter int BORDER_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [PIX_W-1:0]  thresh_off,
    lbp_stream_engine_if.master bus,
    output logic              busy,
    output logic              finish
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_BORDER, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic                            gray_req_q, gray_req_d;
    logic [ADDR_W-1:0]               rd_addr_q, rd_addr_d;
    logic                            mode_q, mode_d;
    logic [PIX_W-1:0]                thr_q, thr_d;
    logic                            cap_pend_q, cap_pend_d;
    logic [ADDR_W-1:0]               cap_addr_q, cap_addr_d;
    logic [CW-1:0]                   cap_c_q, cap_c_d;
    logic [RW-1:0]                   cap_r_q, cap_r_d;
    logic [IMG_W-1:0][PIX_W-1:0]     lb0_q, lb0_d;
    logic [IMG_W-1:0][PIX_W-1:0]     lb1_q, lb1_d;
    logic [2:0][2:0][PIX_W-1:0]      win_q, win_d;
    logic                            res_pend_q, res_pend_d;
    logic [ADDR_W-1:0]               res_addr_q, res_addr_d;
    logic                            lbp_valid_q, lbp_valid_d;
    logic [ADDR_W-1:0]               lbp_addr_q, lbp_addr_d;
    logic [7:0]                      lbp_data_q, lbp_data_d;
    logic [CW-1:0]                   bd_c_q, bd_c_d;
    logic [RW-1:0]                   bd_r_q, bd_r_d;
    logic [ADDR_W-1:0]               bd_addr_q, bd_addr_d;
    logic                            bd_last_q, bd_last_d;
    logic                            busy_q, busy_d;
    logic                            finish_q, finish_d;

    logic                            acc;
    logic                            bd_mid;
    logic [PIX_W:0]                  ref_v;
    logic [7:0]                      code;

    // Window rows: 0 = two rows up (lb1), 1 = previous row (lb0), 2 = current row; column 2 is newest.
    always_comb begin
        ref_v   = {1'b0, win_q[1][1]} + (mode_q ? {1'b0, thr_q} : '0);
        code[0] = {1'b0, win_q[0][0]} >= ref_v;
        code[1] = {1'b0, win_q[0][1]} >= ref_v;
        code[2] = {1'b0, win_q[0][2]} >= ref_v;
        code[3] = {1'b0, win_q[1][0]} >= ref_v;
        code[4] = {1'b0, win_q[1][2]} >= ref_v;
        code[5] = {1'b0, win_q[2][0]} >= ref_v;
        code[6] = {1'b0, win_q[2][1]} >= ref_v;
        code[7] = {1'b0, win_q[2][2]} >= ref_v;
    end

    always_comb begin
        state_d     = state_q;
        gray_req_d  = gray_req_q;
        rd_addr_d   = rd_addr_q;
        mode_d      = mode_q;
        thr_d       = thr_q;
        cap_addr_d  = cap_addr_q;
        cap_c_d     = cap_c_q;
        cap_r_d     = cap_r_q;
        lb0_d       = lb0_q;
        lb1_d       = lb1_q;
        win_d       = win_q;
        res_pend_d  = 1'b0;
        res_addr_d  = res_addr_q;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        bd_c_d      = bd_c_q;
        bd_r_d      = bd_r_q;
        bd_addr_d   = bd_addr_q;
        bd_last_d   = bd_last_q;
        busy_d      = busy_q;
        finish_d    = finish_q;

        acc        = (state_q == S_SCAN) && gray_req_q && bus.gray_ready;
        cap_pend_d = acc;
        bd_mid     = (bd_r_q != '0) && (bd_r_q != RW'(IMG_H - 1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    gray_req_d = 1'b1;
                    rd_addr_d  = '0;
                    cap_addr_d = '0;
                    cap_c_d    = '0;
                    cap_r_d    = '0;
                    bd_c_d     = '0;
                    bd_r_d     = '0;
                    bd_addr_d  = '0;
                    bd_last_d  = 1'b0;
                    mode_d     = mode;
                    thr_d      = thresh_off;
                    busy_d     = 1'b1;
                    finish_d   = 1'b0;
                end
            end
            S_SCAN: begin
                if (acc) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        gray_req_d = 1'b0;
                        state_d    = S_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Nothing in flight: whatever result is on the port now is the last interior one.
                if (!cap_pend_q && !res_pend_q) begin
                    if (BORDER_ZERO != 0) begin
                        state_d = S_BORDER;
                    end else begin
                        state_d  = S_DONE;
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                    end
                end
            end
            S_BORDER: begin
                if (bd_last_q) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                end else begin
                    lbp_valid_d = 1'b1;
                    lbp_addr_d  = bd_addr_q;
                    lbp_data_d  = 8'h00;
                    bd_last_d   = (bd_addr_q == LAST_ADDR);
                    if (bd_mid && bd_c_q == '0) begin
                        bd_c_d    = CW'(IMG_W - 1);
                        bd_addr_d = bd_addr_q + ADDR_W'(IMG_W - 1);
                    end else if (bd_c_q == CW'(IMG_W - 1)) begin
                        bd_c_d    = '0;
                        bd_r_d    = bd_r_q + RW'(1);
                        bd_addr_d = bd_addr_q + ADDR_W'(1);
                    end else begin
                        bd_c_d    = bd_c_q + CW'(1);
                        bd_addr_d = bd_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap_pend_q) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2]    = lb1_q[cap_c_q];
            win_d[1][2]    = lb0_q[cap_c_q];
            win_d[2][2]    = bus.gray_data;
            lb1_d[cap_c_q] = lb0_q[cap_c_q];
            lb0_d[cap_c_q] = bus.gray_data;
            // Columns 0 and 1 still hold the previous row's tail, so they never form a window.
            res_pend_d = (cap_r_q >= RW'(2)) && (cap_c_q >= CW'(2));
            res_addr_d = cap_addr_q - ADDR_W'(IMG_W + 1);
            cap_addr_d = cap_addr_q + ADDR_W'(1);
            if (cap_c_q == CW'(IMG_W - 1)) begin
                cap_c_d = '0;
                cap_r_d = cap_r_q + RW'(1);
            end else begin
                cap_c_d = cap_c_q + CW'(1);
            end
        end

        if (res_pend_q) begin
            lbp_valid_d = 1'b1;
            lbp_addr_d  = res_addr_q;
            lbp_data_d  = code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gray_req_q  <= 1'b0;
            rd_addr_q   <= '0;
            mode_q      <= 1'b0;
            thr_q       <= '0;
            cap_pend_q  <= 1'b0;
            cap_addr_q  <= '0;
            cap_c_q     <= '0;
            cap_r_q     <= '0;
            lb0_q       <= '0;
            lb1_q       <= '0;
            win_q       <= '0;
            res_pend_q  <= 1'b0;
            res_addr_q  <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            bd_c_q      <= '0;
            bd_r_q      <= '0;
            bd_addr_q   <= '0;
            bd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gray_req_q  <= gray_req_d;
            rd_addr_q   <= rd_addr_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            cap_pend_q  <= cap_pend_d;
            cap_addr_q  <= cap_addr_d;
            cap_c_q     <= cap_c_d;
            cap_r_q     <= cap_r_d;
            lb0_q       <= lb0_d;
            lb1_q       <= lb1_d;
            win_q       <= win_d;
            res_pend_q  <= res_pend_d;
            res_addr_q  <= res_addr_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            bd_c_q      <= bd_c_d;
            bd_r_q      <= bd_r_d;
            bd_addr_q   <= bd_addr_d;
            bd_last_q   <= bd_last_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
        end
    end

    assign bus.gray_req  = gray_req_q;
    assign bus.gray_addr = rd_addr_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign busy          = busy_q;
    assign finish        = finish_q;

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Bench for lbp_stream_engine: a 128x128 instance, and two 5x4 instances (with and without border pass)
// compared against a neighbourhood-level LBP model over the stored image.
module tb_lbp_stream_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_b, start_s, start_z;
    logic       mode_i;
    logic [7:0] thr_i;
    logic       busy_b, fin_b, busy_s, fin_s, busy_z, fin_z;

    lbp_stream_engine_if #(.PIX_W(8), .ADDR_W(14)) b_if ();
    lbp_stream_engine_if #(.PIX_W(8), .ADDR_W(5))  s_if ();
    lbp_stream_engine_if #(.PIX_W(8), .ADDR_W(5))  z_if ();

    lbp_stream_engine u_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_i), .thresh_off(thr_i),
        .bus(b_if), .busy(busy_b), .finish(fin_b)
    );
    lbp_stream_engine #(.IMG_W(5), .IMG_H(4), .PIX_W(8), .ADDR_W(5), .BORDER_ZERO(0)) u_s (
        .clk(clk), .reset(reset), .start(start_s), .mode(mode_i), .thresh_off(thr_i),
        .bus(s_if), .busy(busy_s), .finish(fin_s)
    );
    lbp_stream_engine #(.IMG_W(5), .IMG_H(4), .PIX_W(8), .ADDR_W(5), .BORDER_ZERO(1)) u_z (
        .clk(clk), .reset(reset), .start(start_z), .mode(mode_i), .thresh_off(thr_i),
        .bus(z_if), .busy(busy_z), .finish(fin_z)
    );

    int errs = 0;
    int checks = 0;

    // 5x4 image shared by both small instances
    int img [0:19];
    bit rnd_ready = 1'b0;

    // memory models: data appears the cycle after acceptance, junk otherwise
    always @(posedge clk) begin
        b_if.gray_data <= (b_if.gray_req && b_if.gray_ready) ? 8'd50 : 8'($urandom);
        s_if.gray_data <= (s_if.gray_req && s_if.gray_ready) ? 8'(img[s_if.gray_addr]) : 8'($urandom);
        z_if.gray_data <= (z_if.gray_req && z_if.gray_ready) ? 8'(img[z_if.gray_addr]) : 8'($urandom);
    end

    int big_cnt, big_bad, big_first, big_last;
    int s_wa[$], s_wd[$], s_acc[$];
    int z_wa[$], z_wd[$];
    int s_viol;
    bit s_stall;
    int s_stall_addr;

    always @(negedge clk) begin
        if (b_if.lbp_valid === 1'b1) begin
            if (big_cnt == 0) big_first = int'(b_if.lbp_addr);
            big_last = int'(b_if.lbp_addr);
            if (b_if.lbp_data !== 8'hFF) big_bad++;
            big_cnt++;
        end
        if (z_if.lbp_valid === 1'b1) begin
            z_wa.push_back(int'(z_if.lbp_addr));
            z_wd.push_back(int'(z_if.lbp_data));
        end
        if (s_if.lbp_valid === 1'b1) begin
            s_wa.push_back(int'(s_if.lbp_addr));
            s_wd.push_back(int'(s_if.lbp_data));
        end
        if (s_stall && int'(s_if.gray_addr) != s_stall_addr) s_viol++;
        s_if.gray_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        s_stall      = s_if.gray_req && !s_if.gray_ready;
        s_stall_addr = int'(s_if.gray_addr);
        if (s_if.gray_req && s_if.gray_ready) s_acc.push_back(int'(s_if.gray_addr));
    end

    // ---------------- reference model ----------------
    int exp_a[$], exp_d[$];

    function automatic int ref_code(int r, int c, bit md, int thr);
        int dr[8];
        int dc[8];
        int lim;
        int code;
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        lim = img[r * 5 + c] + (md ? thr : 0);
        code = 0;
        for (int k = 0; k < 8; k++)
            if (img[(r + dr[k]) * 5 + (c + dc[k])] >= lim) code += (1 << k);
        return code;
    endfunction

    task automatic build_exp(input bit md, input int thr, input bit border);
        exp_a.delete();
        exp_d.delete();
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 3; c++) begin
                exp_a.push_back(r * 5 + c);
                exp_d.push_back(ref_code(r, c, md, thr));
            end
        if (border)
            for (int a = 0; a < 20; a++)
                if (a / 5 == 0 || a / 5 == 3 || a % 5 == 0 || a % 5 == 4) begin
                    exp_a.push_back(a);
                    exp_d.push_back(0);
                end
    endtask

    task automatic set_ramp();
        for (int a = 0; a < 20; a++) img[a] = a / 5 + a % 5;
    endtask

    task automatic run_small(input bit md, input int thr, input bit rnd, input bit restart_mid,
                             output bit ok);
        mode_i = md;
        thr_i = 8'(thr);
        rnd_ready = rnd;
        s_wa.delete(); s_wd.delete(); s_acc.delete();
        s_viol = 0;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        if (restart_mid) begin
            repeat (5) @(posedge clk);
            #1 start_s = 1'b1;
            @(posedge clk); #1 start_s = 1'b0;
        end
        for (int n = 0; n < 400 && !fin_s; n++) begin
            @(posedge clk); #1;
        end
        ok = fin_s;
        repeat (4) @(posedge clk);
        #1;
        rnd_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [13:0] bv;
        logic [4:0]  sv;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bv = {b_if.gray_req, b_if.lbp_valid, busy_b, fin_b, b_if.gray_addr[9:0]};
        if (bv !== 14'd0 || b_if.lbp_addr !== 14'd0 || b_if.lbp_data !== 8'd0) begin
            errs++; $display("FAIL reset_big: outs=%h addr=%0d data=%0d, want 0", bv, b_if.lbp_addr, b_if.lbp_data);
        end
        checks++;
        sv = {s_if.gray_req, s_if.lbp_valid, busy_s, fin_s, 1'b0};
        if (sv !== 5'd0 || s_if.gray_addr !== 5'd0 || s_if.lbp_addr !== 5'd0 || s_if.lbp_data !== 8'd0) begin
            errs++; $display("FAIL reset_small: flags=%b gaddr=%0d", sv, s_if.gray_addr);
        end
        checks++;
        if ({z_if.gray_req, z_if.lbp_valid, busy_z, fin_z} !== 4'd0) begin
            errs++; $display("FAIL reset_border: flags=%b want 0000", {z_if.gray_req, z_if.lbp_valid, busy_z, fin_z});
        end
        checks++;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_full_frame();
        int cnt_at_fin;
        mode_i = 1'b0; thr_i = 8'd0;
        big_cnt = 0; big_bad = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        if (busy_b !== 1'b1) begin errs++; $display("FAIL big_busy: got %b want 1", busy_b); end
        checks++;
        for (int n = 0; n < 20000 && !fin_b; n++) begin
            @(posedge clk); #1;
        end
        if (fin_b !== 1'b1 || busy_b !== 1'b0) begin
            errs++; $display("FAIL big_finish: finish=%b busy=%b want 1/0", fin_b, busy_b);
        end
        checks++;
        cnt_at_fin = big_cnt;
        repeat (40) @(posedge clk);
        #1;
        if (big_cnt != 15876 || cnt_at_fin != 15876) begin
            errs++; $display("FAIL big_count: got %0d (at finish %0d) want 15876", big_cnt, cnt_at_fin);
        end
        checks++;
        if (big_bad != 0) begin errs++; $display("FAIL big_data: %0d codes not 0xFF, want 0", big_bad); end
        checks++;
        if (big_first != 129 || big_last != 16254) begin
            errs++; $display("FAIL big_addr: first=%0d last=%0d want 129/16254", big_first, big_last);
        end
        checks++;
    endtask

    task automatic test_ramp_mode0();
        int lit_a[6];
        bit ok;
        lit_a = '{6, 7, 8, 11, 12, 13};
        set_ramp();
        build_exp(1'b0, 0, 1'b0);
        run_small(1'b0, 0, 1'b0, 1'b0, ok);
        if (!ok) begin errs++; $display("FAIL ramp0_timeout: finish=%b want 1", fin_s); end
        checks++;
        if (s_wa.size() != 6) begin errs++; $display("FAIL ramp0_count: got %0d want 6", s_wa.size()); end
        checks++;
        for (int i = 0; i < 6 && i < s_wa.size(); i++) begin
            if (s_wa[i] != lit_a[i] || s_wd[i] != 'hF4 || s_wd[i] != exp_d[i]) begin
                errs++; $display("FAIL ramp0_w%0d: got addr=%0d data=%h want %0d/f4", i, s_wa[i], s_wd[i], lit_a[i]);
            end
            checks++;
        end
        if (busy_s !== 1'b0) begin errs++; $display("FAIL ramp0_busy: got %b want 0", busy_s); end
        checks++;
    endtask

    task automatic test_ramp_mode1();
        int thrs[2];
        int want[2];
        bit ok;
        thrs = '{1, 200};
        want = '{'hD0, 0};
        set_ramp();
        for (int t = 0; t < 2; t++) begin
            build_exp(1'b1, thrs[t], 1'b0);
            run_small(1'b1, thrs[t], 1'b0, 1'b0, ok);
            if (!ok || s_wa.size() != 6) begin
                errs++; $display("FAIL mode1_t%0d_count: got %0d finish=%b want 6/1", thrs[t], s_wa.size(), ok);
            end
            checks++;
            for (int i = 0; i < 6 && i < s_wa.size(); i++) begin
                if (s_wa[i] != exp_a[i] || s_wd[i] != want[t] || exp_d[i] != want[t]) begin
                    errs++; $display("FAIL mode1_t%0d_w%0d: got %0d/%h want %0d/%h", thrs[t], i, s_wa[i], s_wd[i], exp_a[i], want[t]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        int bad_acc;
        set_ramp();
        build_exp(1'b0, 0, 1'b0);
        run_small(1'b0, 0, 1'b1, 1'b0, ok);
        if (!ok || s_wa.size() != exp_a.size()) begin
            errs++; $display("FAIL rdy_count: got %0d finish=%b want %0d/1", s_wa.size(), ok, exp_a.size());
        end
        checks++;
        for (int i = 0; i < exp_a.size() && i < s_wa.size(); i++) begin
            if (s_wa[i] != exp_a[i] || s_wd[i] != exp_d[i]) begin
                errs++; $display("FAIL rdy_w%0d: got %0d/%h want %0d/%h", i, s_wa[i], s_wd[i], exp_a[i], exp_d[i]);
            end
            checks++;
        end
        if (s_viol != 0) begin errs++; $display("FAIL rdy_addr_stable: %0d changes while stalled, want 0", s_viol); end
        checks++;
        bad_acc = 0;
        for (int i = 0; i < s_acc.size(); i++) if (s_acc[i] != i) bad_acc++;
        if (s_acc.size() != 20 || bad_acc != 0) begin
            errs++; $display("FAIL rdy_accepts: got %0d accepts, %0d out of order, want 20/0", s_acc.size(), bad_acc);
        end
        checks++;
    endtask

    task automatic test_random_images();
        bit ok;
        bit md;
        int thr;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 20; a++) img[a] = (it % 2) ? $urandom_range(180, 255) : $urandom_range(0, 255);
            md = 1'($urandom_range(0, 1));
            thr = $urandom_range(0, 80);
            build_exp(md, thr, 1'b0);
            run_small(md, thr, 1'b1, 1'b0, ok);
            if (!ok || s_wa.size() != 6) begin
                errs++; $display("FAIL rand%0d_count: got %0d finish=%b want 6/1", it, s_wa.size(), ok);
            end
            checks++;
            for (int i = 0; i < 6 && i < s_wa.size(); i++) begin
                if (s_wa[i] != exp_a[i] || s_wd[i] != exp_d[i]) begin
                    errs++; $display("FAIL rand%0d_w%0d: got %0d/%h want %0d/%h", it, i, s_wa[i], s_wd[i], exp_a[i], exp_d[i]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_border();
        set_ramp();
        build_exp(1'b0, 0, 1'b1);
        mode_i = 1'b0; thr_i = 8'd0;
        z_wa.delete(); z_wd.delete();
        @(posedge clk); #1 start_z = 1'b1;
        @(posedge clk); #1 start_z = 1'b0;
        for (int n = 0; n < 400 && !fin_z; n++) begin
            @(posedge clk); #1;
        end
        if (fin_z !== 1'b1 || busy_z !== 1'b0) begin
            errs++; $display("FAIL border_finish: finish=%b busy=%b want 1/0", fin_z, busy_z);
        end
        checks++;
        if (z_wa.size() != 20) begin
            errs++; $display("FAIL border_count: got %0d at finish want 20", z_wa.size());
        end
        checks++;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < exp_a.size() && i < z_wa.size(); i++) begin
            if (z_wa[i] != exp_a[i] || z_wd[i] != exp_d[i]) begin
                errs++; $display("FAIL border_w%0d: got %0d/%h want %0d/%h", i, z_wa[i], z_wd[i], exp_a[i], exp_d[i]);
            end
            checks++;
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int bad_acc;
        set_ramp();
        mode_i = 1'b0; thr_i = 8'd0;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        if ({s_if.gray_req, s_if.lbp_valid, busy_s, fin_s} !== 4'd0 || s_if.gray_addr !== 5'd0 ||
            s_if.lbp_addr !== 5'd0 || s_if.lbp_data !== 8'd0) begin
            errs++; $display("FAIL midrst_outs: req=%b vld=%b busy=%b fin=%b gaddr=%0d laddr=%0d data=%h want all 0",
                             s_if.gray_req, s_if.lbp_valid, busy_s, fin_s, s_if.gray_addr, s_if.lbp_addr, s_if.lbp_data);
        end
        checks++;
        @(negedge clk) reset = 1'b0;
        build_exp(1'b0, 0, 1'b0);
        run_small(1'b0, 0, 1'b0, 1'b1, ok);
        if (!ok || s_wa.size() != 6) begin
            errs++; $display("FAIL midrst_count: got %0d finish=%b want 6/1", s_wa.size(), ok);
        end
        checks++;
        for (int i = 0; i < 6 && i < s_wa.size(); i++) begin
            if (s_wa[i] != exp_a[i] || s_wd[i] != 'hF4) begin
                errs++; $display("FAIL midrst_w%0d: got %0d/%h want %0d/f4", i, s_wa[i], s_wd[i], exp_a[i]);
            end
            checks++;
        end
        bad_acc = 0;
        for (int i = 0; i < s_acc.size(); i++) if (s_acc[i] != i) bad_acc++;
        if (s_acc.size() != 20 || bad_acc != 0) begin
            errs++; $display("FAIL midrst_accepts: got %0d accepts, %0d out of order, want 20/0", s_acc.size(), bad_acc);
        end
        checks++;
    endtask

    initial begin
        reset = 1'b1;
        start_b = 1'b0; start_s = 1'b0; start_z = 1'b0;
        mode_i = 1'b0; thr_i = 8'd0;
        b_if.gray_ready = 1'b1;
        z_if.gray_ready = 1'b1;
        s_viol = 0; s_stall = 1'b0; s_stall_addr = 0;
        big_cnt = 0; big_bad = 0; big_first = 0; big_last = 0;
        for (int a = 0; a < 20; a++) img[a] = 0;
        test_reset();
        test_full_frame();
        test_ramp_mode0();
        test_ramp_mode1();
        test_random_ready();
        test_random_images();
        test_border();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/lbp_stream_engine.md
Name: lbp_stream_engine

Overview:
- Parametrised successor to the team's 3x3 local-binary-pattern engine; works on any IMG_W x IMG_H image with PIX_W-bit pixels.
- Reads every pixel of the gray memory exactly once, in raster order, through a req/ready port.
- Holds the two previous image rows in internal line buffers and slides a 3x3 window.
- Adds a threshold-offset compare mode and an optional zero-fill pass for border pixels, then signals finish.

Parameters:
- IMG_W, 128: image width in pixels; must be >= 3.
- IMG_H, 128: image height in pixels; must be >= 3.
- PIX_W, 8: gray pixel width in bits.
- ADDR_W, 14: address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- BORDER_ZERO, 0: 1 = after the interior pass, write 0 to every border pixel address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when in IDLE or DONE.
- mode  in  1  0: bit = (nbr >= ctr); 1: bit = (nbr >= ctr + thresh_off).
- thresh_off  in  PIX_W  offset used in mode 1; sampled at start.
- gray_req  out  1  read request.
- gray_addr  out  ADDR_W  read address, linear r*IMG_W+c.
- gray_ready  in  1  memory accepts the request this cycle.
- gray_data  in  PIX_W  read data, valid one cycle after acceptance.
- lbp_valid  out  1  write strobe, one cycle per result.
- lbp_addr  out  ADDR_W  result address, linear r*IMG_W+c.
- lbp_data  out  8  LBP code.
- busy  out  1  high from start until DONE.
- finish  out  1  high in DONE; held until the next start.

Behaviour:
- Reset: all outputs are 0. State = IDLE. Address counters, window, and line buffers are cleared. Reset mid-frame aborts immediately; there is no partial finish.
- States:
  - IDLE -> SCAN on start.
  - SCAN -> DRAIN after the last address (IMG_W*IMG_H-1) is accepted.
  - DRAIN -> BORDER when BORDER_ZERO=1; otherwise DRAIN -> DONE. DRAIN lasts until the last interior result has issued.
  - BORDER -> DONE after the last border write.
  - DONE -> SCAN on start.
  - start is ignored in SCAN, DRAIN and BORDER.
- Read handshake: in SCAN, gray_req=1. A request is accepted at a rising edge where gray_req&&gray_ready. The address then increments by 1. gray_addr is held stable while gray_ready=0. gray_req drops the cycle after the final acceptance.
- Capture: gray_data is sampled on the edge after acceptance and shifted into the window and line buffers. Pipeline stalls only by not advancing; no data is lost.
- Result trigger: when the pixel at (r,c) with r>=2 and c>=2 is captured, the window centred at (r-1,c-1) is complete.
  - lbp_valid pulses on the following edge (2 edges after acceptance).
  - lbp_addr = (r-1)*IMG_W+(c-1).
  - There is no output backpressure.
- Code weights:
  - top-left=1, top=2, top-right=4.
  - left=8, right=16.
  - bottom-left=32, bottom=64, bottom-right=128.
- Mode 1 arithmetic: ctr+thresh_off is computed in PIX_W+1 bits with no wrap. A sum > 2^PIX_W-1 makes every compare false (code 0).
- Window at row wrap: columns from the previous row never form a result. No output is issued for c<2 of any captured row.
- Interior count: exactly (IMG_W-2)*(IMG_H-2) writes, in raster order of the centre pixel.
- BORDER pass: one write per cycle with lbp_data=0, in raster order of border addresses.
  - Border addresses are row 0, row IMG_H-1, and columns 0 and IMG_W-1 of rows 1..IMG_H-2.
  - Count = 2*IMG_W + 2*(IMG_H-2).
- finish rises the cycle after the final write; busy falls the same cycle.

Test Plan:
- Defaults, all pixels 50, mode 0, gray_ready=1 -> 15876 writes, all 0xFF, first lbp_addr=129, last=16254; then finish=1 and no border writes.
- IMG_W=5, IMG_H=4, pixel=r+c, mode 0 -> 6 writes at addresses 6,7,8,11,12,13, each lbp_data=0xF4.
- Same image, mode 1, thresh_off=1 -> 6 writes, each 0xD0; with thresh_off=200 -> each 0x00.
- Same image, gray_ready random 50% -> identical write sequence to scenario 2; gray_addr unchanged during every ready-low cycle; no address skipped or repeated.
- BORDER_ZERO=1, 5x4 ramp -> 6 interior writes, then 14 zero writes at 0,1,2,3,4,5,9,10,14,15,16,17,18,19; then finish.
- Reset asserted mid-SCAN -> all outputs 0 immediately. A following start reruns scenario 2 with correct results; start pulsed during SCAN is ignored.
